pwr_load_sequencer: RTL and testbench
=====================================

Name: pwr_load_sequencer

Overview:
Parametrised programmable power-load generator for the VCK190 power-measurement setup, clocked from the CIPS 100 MHz PL clock. It drives NUM_CH banks of toggling flops whose switching activity follows a scheduled activity level. Supported schedules are static, triangle ramp and square step. It reports status on the user LEDs and keeps an activity event counter, so board-level power can be correlated with a known toggle rate.

Parameters:
NUM_CH, 8, number of independent load channels
LOAD_W, 64, flops per channel bank
LEVEL_W, 4, activity-level width; duty = level / 2^LEVEL_W
STEP_CYCLES, 1000000, dwell cycles per ramp/step level (>=2)
HEARTBEAT_DIV, 50000000, cycles per heartbeat LED toggle (>=2)

Ports:
clk_in  in  1  the single clock (CIPS 100 MHz); all logic on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  run enable
mode  in  2  0 static, 1 ramp, 2 step, 3 reserved
static_level  in  LEVEL_W  level for static mode and the step-high phase
ch_enable  in  NUM_CH  per-channel toggle enable
load_out  out  NUM_CH  bit 0 of each bank, registered
cur_level  out  LEVEL_W  currently applied level
busy  out  1  FSM not in IDLE
act_cnt  out  32  channel-toggle events since reset, saturating
USER_LED  out  4  [0] heartbeat, [1] busy, [3:2] state class

Behaviour:
- Reset values: all outputs 0, all banks 0, duty_cnt 0, dwell counter 0, heartbeat counter 0, FSM in IDLE. Reset has priority over every other input.
- duty_cnt: LEVEL_W-bit free-running counter that wraps.
- gate = (duty_cnt < cur_level). Level 0 never toggles. Max level toggles (2^LEVEL_W - 1) of every 2^LEVEL_W cycles.
- Toggle: on any cycle where gate && ch_enable[i], bank[i] <= ~bank[i]; otherwise bank[i] holds.
- Bank flops carry keep/dont_touch so they are not optimised away.
- load_out[i] <= next bank[i][0], so load_out updates on the same edge as the bank.
- act_cnt: each cycle adds popcount(ch_enable) when gate=1. It saturates at 0xFFFFFFFF and never wraps.
- FSM states: IDLE, STATIC, RAMP_UP, RAMP_DOWN, STEP_HI, STEP_LO. State, cur_level and the dwell counter all update on the same edge.
- IDLE: cur_level=0. Leaves when en=1 and mode!=3, with mode latched as run_mode:
  - mode 0 -> STATIC
  - mode 1 -> RAMP_UP at level 0
  - mode 2 -> STEP_HI at static_level
  - mode 3 -> stay in IDLE
- STATIC: cur_level tracks static_level every cycle.
- RAMP_UP: after STEP_CYCLES cycles at a level, go to level+1. After the dwell at max level, go to RAMP_DOWN at max-1.
- RAMP_DOWN: decrements each dwell. After the dwell at 0, go to RAMP_UP at 1. Resulting sequence: 0,1,…,max,max-1,…,0,1,…
- STEP_HI: level = static_level, sampled at entry, for STEP_CYCLES. Then STEP_LO at level 0 for STEP_CYCLES, then back to STEP_HI (static_level re-sampled). Repeats.
- Dwell counter clears on every state or level change.
- en=0, or mode != run_mode, in any non-IDLE state: go to IDLE on the next edge with cur_level=0. Banks hold their value. If en=1 and mode is valid, re-entry happens on the following edge.
- Latency: en rises sampled at edge t -> busy=1 and cur_level valid after edge t. The first toggle is no earlier than edge t+1.
- USER_LED[0]: toggles every HEARTBEAT_DIV cycles, independent of en.
- USER_LED[1] = busy.
- USER_LED[3:2]: 00 IDLE, 01 STATIC, 10 RAMP_*, 11 STEP_*.
- Reset mid-run: next cycle all outputs match reset values. act_cnt clears.

Test Plan:
Bench params for all scenarios: NUM_CH=4, LOAD_W=8, LEVEL_W=2, STEP_CYCLES=4, HEARTBEAT_DIV=10.
1. Reset held for 3 cycles, then released with en=0 -> all outputs 0. USER_LED[0] toggles at cycles 10, 20, 30.
2. mode=0, static_level=2, ch_enable=0011, en=1 for 16 cycles -> busy=1, LED[3:2]=01. Channels 0/1 toggle on 8 cycles (duty_cnt 0,1 each period). act_cnt=16. load_out[3:2]=00.
3. mode=1, ch_enable=1111 -> cur_level follows 0,1,2,3,2,1,0,1 with each value held 4 cycles. LED[3:2]=10. act_cnt increments by 4 on each gated cycle.
4. mode=2, static_level=3 -> cur_level follows 3×4 cycles, 0×4 cycles, 3×4 cycles. Changing static_level to 1 mid-STEP_HI takes effect only at the next STEP_HI entry.
5. Mid-ramp at level 2, drop en -> next cycle cur_level=0, busy=0, bank values frozen. Raise en again -> RAMP_UP restarts at level 0.
6. Mid-run, pulse rst for 1 cycle -> all outputs and act_cnt are 0 on the next cycle. With en=1 held, busy=1 one cycle after rst falls.

Source files
------------

// File: rtl/pwr_load_sequencer.sv
// pwr_load_sequencer: scheduled toggling-flop power load with LED status and activity counter
module pwr_load_sequencer #(
    parameter int NUM_CH        = 8,
    parameter int LOAD_W        = 64,
    parameter int LEVEL_W       = 4,
    parameter int STEP_CYCLES   = 1000000,
    parameter int HEARTBEAT_DIV = 50000000
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [LEVEL_W-1:0] static_level,
    input  logic [NUM_CH-1:0]  ch_enable,
    output logic [NUM_CH-1:0]  load_out,
    output logic [LEVEL_W-1:0] cur_level,
    output logic               busy,
    output logic [31:0]        act_cnt,
    output logic [3:0]         USER_LED
);
    localparam int DW = $clog2(STEP_CYCLES);
    localparam int HW = $clog2(HEARTBEAT_DIV);
    localparam logic [LEVEL_W-1:0] MAX = '1;
    localparam logic [LEVEL_W-1:0] ONE = LEVEL_W'(1);

    typedef enum logic [2:0] {IDLE, STATIC, RAMP_UP, RAMP_DOWN, STEP_HI, STEP_LO} state_t;

    state_t             state;
    logic [1:0]         run_mode;
    logic [1:0]         led_class;
    logic [DW-1:0]      dwell;
    logic [LEVEL_W-1:0] duty_cnt;
    logic [HW-1:0]      hb_cnt;
    logic               hb;
    logic               gate;
    logic               start;
    logic               dwell_done;
    logic [32:0]        act_sum;

    (* keep = "true", dont_touch = "true" *) logic [LOAD_W-1:0] bank [NUM_CH];

    assign gate       = duty_cnt < cur_level;
    assign start      = en && mode != 2'd3;
    assign dwell_done = dwell == DW'(STEP_CYCLES - 1);
    assign act_sum    = {1'b0, act_cnt} + 33'($countones(ch_enable));
    assign USER_LED   = {led_class, busy, hb};

    // Duty phase counter and free-running heartbeat, both independent of en
    always_ff @(posedge clk_in) begin
        if (rst) begin
            duty_cnt <= '0;
            hb_cnt   <= '0;
            hb       <= 1'b0;
        end else begin
            duty_cnt <= duty_cnt + ONE;
            hb_cnt   <= hb_cnt == HW'(HEARTBEAT_DIV - 1) ? '0 : hb_cnt + HW'(1);
            hb       <= hb_cnt == HW'(HEARTBEAT_DIV - 1) ? ~hb : hb;
        end
    end

    // Schedule FSM: state, level, dwell and status outputs all move on one edge
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= IDLE;
            run_mode  <= 2'd0;
            led_class <= 2'b00;
            busy      <= 1'b0;
            dwell     <= '0;
            cur_level <= '0;
        end else if (state != IDLE && (!en || mode != run_mode)) begin
            state     <= IDLE;
            led_class <= 2'b00;
            busy      <= 1'b0;
            dwell     <= '0;
            cur_level <= '0;
        end else begin
            case (state)
                IDLE: begin
                    run_mode  <= mode;
                    busy      <= start;
                    dwell     <= '0;
                    led_class <= start ? mode + 2'd1 : 2'b00;
                    state     <= !start ? IDLE : mode == 2'd0 ? STATIC : mode == 2'd1 ? RAMP_UP : STEP_HI;
                    cur_level <= (start && mode != 2'd1) ? static_level : '0;
                end
                STATIC: begin
                    dwell     <= '0;
                    cur_level <= static_level;
                end
                RAMP_UP: begin
                    dwell <= dwell_done ? '0 : dwell + DW'(1);
                    if (dwell_done) begin
                        state     <= cur_level == MAX ? RAMP_DOWN : RAMP_UP;
                        cur_level <= cur_level == MAX ? MAX - ONE : cur_level + ONE;
                    end
                end
                RAMP_DOWN: begin
                    dwell <= dwell_done ? '0 : dwell + DW'(1);
                    if (dwell_done) begin
                        state     <= cur_level == '0 ? RAMP_UP : RAMP_DOWN;
                        cur_level <= cur_level == '0 ? ONE : cur_level - ONE;
                    end
                end
                STEP_HI: begin
                    dwell <= dwell_done ? '0 : dwell + DW'(1);
                    if (dwell_done) begin
                        state     <= STEP_LO;
                        cur_level <= '0;
                    end
                end
                STEP_LO: begin
                    dwell <= dwell_done ? '0 : dwell + DW'(1);
                    if (dwell_done) begin
                        state     <= STEP_HI;
                        cur_level <= static_level;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    led_class <= 2'b00;
                    dwell     <= '0;
                    cur_level <= '0;
                end
            endcase
        end
    end

    // Load banks: whole bank inverts on gated cycles; load_out mirrors the new bit 0
    always_ff @(posedge clk_in) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) bank[i] <= '0;
            load_out <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (gate && ch_enable[i]) begin
                    bank[i]     <= ~bank[i];
                    load_out[i] <= ~bank[i][0];
                end
            end
        end
    end

    // Saturating count of channel-toggle events
    always_ff @(posedge clk_in) begin
        if (rst) act_cnt <= '0;
        else if (gate) act_cnt <= act_sum[32] ? '1 : act_sum[31:0];
    end
endmodule

// File: tb/tb_pwr_load_sequencer.sv
// tb_pwr_load_sequencer: scenario tasks with queue-based expected-value scoreboard
module tb_pwr_load_sequencer;
    localparam int NUM_CH = 4, LOAD_W = 8, LEVEL_W = 2, STEP_CYCLES = 4, HEARTBEAT_DIV = 10;

    logic              clk_in = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic [1:0]        static_level = 2'd0;
    logic [3:0]        ch_enable = 4'd0;
    logic [3:0]        load_out;
    logic [1:0]        cur_level;
    logic              busy;
    logic [31:0]       act_cnt;
    logic [3:0]        USER_LED;

    int passed = 0;
    int total  = 0;
    int lvl_q[$];
    int act_q[$];
    int hb_q[$];

    pwr_load_sequencer #(
        .NUM_CH(NUM_CH), .LOAD_W(LOAD_W), .LEVEL_W(LEVEL_W),
        .STEP_CYCLES(STEP_CYCLES), .HEARTBEAT_DIV(HEARTBEAT_DIV)
    ) dut (
        .clk_in(clk_in), .rst(rst), .en(en), .mode(mode), .static_level(static_level),
        .ch_enable(ch_enable), .load_out(load_out), .cur_level(cur_level), .busy(busy),
        .act_cnt(act_cnt), .USER_LED(USER_LED)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        en  = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        int e;
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) tick();
        total++; if ({load_out, cur_level, busy, USER_LED} !== 11'd0 || act_cnt !== 32'd0) $display("FAIL reset_outputs: got load=%b lvl=%0d busy=%b led=%b act=%0d want all 0", load_out, cur_level, busy, USER_LED, act_cnt); else passed++;
        rst = 1'b0;
        for (int k = 1; k <= 35; k++) begin
            hb_q.push_back((k / 10) % 2);
            tick();
            e = hb_q.pop_front();
            total++; if (USER_LED[0] !== e[0]) $display("FAIL heartbeat k=%0d: got %b want %b", k, USER_LED[0], e[0]); else passed++;
        end
        total++; if (busy !== 1'b0 || act_cnt !== 32'd0 || cur_level !== 2'd0) $display("FAIL idle_after_reset: got busy=%b act=%0d lvl=%0d want 0", busy, act_cnt, cur_level); else passed++;
    endtask

    task automatic test_mode3;
        mode = 2'd3;
        en   = 1'b1;
        tick();
        tick();
        total++; if (busy !== 1'b0 || USER_LED[3:1] !== 3'b000) $display("FAIL mode3_idle: got busy=%b led=%b want idle", busy, USER_LED); else passed++;
        en = 1'b0;
    endtask

    task automatic test_static;
        int toggles;
        logic prev;
        do_reset();
        mode = 2'd0; static_level = 2'd2; ch_enable = 4'b0011; en = 1'b1;
        tick();
        total++; if (busy !== 1'b1 || cur_level !== 2'd2 || USER_LED[3:1] !== 3'b011) $display("FAIL static_entry: got busy=%b lvl=%0d led=%b want 1/2/011x", busy, cur_level, USER_LED); else passed++;
        toggles = 0;
        prev = load_out[0];
        repeat (16) begin
            tick();
            if (load_out[0] !== prev) toggles++;
            prev = load_out[0];
        end
        total++; if (toggles !== 8) $display("FAIL static_toggles: got %0d want 8", toggles); else passed++;
        total++; if (act_cnt !== 32'd16) $display("FAIL static_act: got %0d want 16", act_cnt); else passed++;
        total++; if (load_out !== 4'b0000) $display("FAIL static_load: got %b want 0000", load_out); else passed++;
    endtask

    task automatic test_ramp;
        int ramp[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
        int exp_act, prev_lvl, el, ea;
        do_reset();
        mode = 2'd1; ch_enable = 4'hF; en = 1'b1;
        exp_act = 0;
        for (int k = 0; k < 32; k++) begin
            prev_lvl = k > 0 ? ramp[(k - 1) / 4] : 0;
            if (k > 0 && (k % 4) < prev_lvl) exp_act += 4;
            lvl_q.push_back(ramp[k / 4]);
            act_q.push_back(exp_act);
            tick();
            el = lvl_q.pop_front();
            ea = act_q.pop_front();
            total++; if (cur_level !== el[1:0]) $display("FAIL ramp_level k=%0d: got %0d want %0d", k, cur_level, el); else passed++;
            total++; if (act_cnt !== ea) $display("FAIL ramp_act k=%0d: got %0d want %0d", k, act_cnt, ea); else passed++;
        end
        total++; if (USER_LED[3:1] !== 3'b101) $display("FAIL ramp_led: got %b want 101x", USER_LED); else passed++;
    endtask

    task automatic test_step;
        int stp[5] = '{3, 0, 3, 0, 1};
        int el;
        do_reset();
        mode = 2'd2; static_level = 2'd3; ch_enable = 4'hF; en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            lvl_q.push_back(stp[k / 4]);
            tick();
            el = lvl_q.pop_front();
            total++; if (cur_level !== el[1:0]) $display("FAIL step_level k=%0d: got %0d want %0d", k, cur_level, el); else passed++;
            if (k == 9) static_level = 2'd1;
        end
        total++; if (USER_LED[3:1] !== 3'b111) $display("FAIL step_led: got %b want 111x", USER_LED); else passed++;
    endtask

    task automatic test_en_drop;
        int ramp[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
        logic [3:0] exp_load;
        do_reset();
        mode = 2'd1; ch_enable = 4'b0011; en = 1'b1;
        exp_load = 4'b0000;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0 && (k % 4) < ramp[(k - 1) / 4]) exp_load ^= ch_enable;
            tick();
        end
        total++; if (cur_level !== 2'd2) $display("FAIL drop_prelevel: got %0d want 2", cur_level); else passed++;
        ch_enable = 4'hF;
        en = 1'b0;
        if ((9 % 4) < 2) exp_load ^= ch_enable;
        tick();
        total++; if (cur_level !== 2'd0 || busy !== 1'b0 || USER_LED[3:1] !== 3'b000) $display("FAIL drop_idle: got lvl=%0d busy=%b led=%b want 0/0/000x", cur_level, busy, USER_LED); else passed++;
        total++; if (load_out !== exp_load) $display("FAIL drop_load: got %b want %b", load_out, exp_load); else passed++;
        repeat (3) tick();
        total++; if (load_out !== exp_load) $display("FAIL drop_frozen: got %b want %b", load_out, exp_load); else passed++;
        en = 1'b1;
        tick();
        total++; if (busy !== 1'b1 || cur_level !== 2'd0 || USER_LED[3:1] !== 3'b101) $display("FAIL reenter: got busy=%b lvl=%0d led=%b want 1/0/101x", busy, cur_level, USER_LED); else passed++;
        repeat (4) tick();
        total++; if (cur_level !== 2'd1) $display("FAIL reenter_ramp: got %0d want 1", cur_level); else passed++;
    endtask

    task automatic test_mode_change;
        static_level = 2'd2;
        mode = 2'd0;
        tick();
        total++; if (busy !== 1'b0 || cur_level !== 2'd0) $display("FAIL modechg_idle: got busy=%b lvl=%0d want 0/0", busy, cur_level); else passed++;
        tick();
        total++; if (busy !== 1'b1 || cur_level !== 2'd2 || USER_LED[3:2] !== 2'b01) $display("FAIL modechg_static: got busy=%b lvl=%0d led=%b want 1/2/01xx", busy, cur_level, USER_LED); else passed++;
    endtask

    task automatic test_rst_mid;
        mode = 2'd0; static_level = 2'd3; ch_enable = 4'hF; en = 1'b1;
        repeat (6) tick();
        total++; if (act_cnt === 32'd0) $display("FAIL rstmid_active: got act=%0d want nonzero", act_cnt); else passed++;
        rst = 1'b1;
        tick();
        total++; if ({load_out, cur_level, busy, USER_LED} !== 11'd0 || act_cnt !== 32'd0) $display("FAIL rstmid_clear: got load=%b lvl=%0d busy=%b led=%b act=%0d want all 0", load_out, cur_level, busy, USER_LED, act_cnt); else passed++;
        rst = 1'b0;
        tick();
        total++; if (busy !== 1'b1 || cur_level !== 2'd3 || act_cnt !== 32'd0) $display("FAIL rstmid_resume: got busy=%b lvl=%0d act=%0d want 1/3/0", busy, cur_level, act_cnt); else passed++;
    endtask

    initial begin
        test_reset();
        test_mode3();
        test_static();
        test_ramp();
        test_step();
        test_en_drop();
        test_mode_change();
        test_rst_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
